// File: rtl/br_amba_pkg.sv
// Shared APB constants for the br_amba family of blocks.
package br_amba;
  localparam int ApbProtWidth = 3;
  localparam int ApbStrbWidth = 4;
  localparam int ApbDataWidth = 32;
endpackage

// File: rtl/br_arb_rr.sv
// Round-robin arbiter: combinational grant searching upward from a priority pointer.
// The pointer moves just past the winner whenever update is high and a grant exists.
module br_arb_rr #(
  parameter int NumRequesters = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumRequesters-1:0]           request,
  input  logic                               update,
  output logic [NumRequesters-1:0]           grant,
  output logic [$clog2(NumRequesters)-1:0]   grant_idx
);
  localparam int IdxWidth = $clog2(NumRequesters);
  localparam logic [IdxWidth:0]   NumReq  = (IdxWidth+1)'(NumRequesters);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumRequesters - 1);

  logic [IdxWidth-1:0] ptr;
  logic [IdxWidth:0]   cand;
  logic                found;

  // Candidate k is (ptr + k) mod NumRequesters; the extra bit absorbs the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      cand = {1'b0, ptr} + (IdxWidth+1)'(k);
      if (cand >= NumReq) cand = cand - NumReq;
      if (!found && request[cand[IdxWidth-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IdxWidth-1:0];
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/br_amba_apb_arbiter.sv
// N:1 APB arbiter: round-robin grant, registered downstream request, combinational response demux.
// Request seen at t -> psel_out at t+1 -> penable_out at t+2; one transfer in flight, one IDLE cycle between.
module br_amba_apb_arbiter
  import br_amba::*;
#(
  parameter int NumRequesters = 2,
  parameter int AddrWidth     = 12
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NumRequesters-1:0][AddrWidth-1:0]       paddr_in,
  input  logic [NumRequesters-1:0]                      psel_in,
  input  logic [NumRequesters-1:0]                      penable_in,
  input  logic [NumRequesters-1:0][ApbProtWidth-1:0]    pprot_in,
  input  logic [NumRequesters-1:0][ApbStrbWidth-1:0]    pstrb_in,
  input  logic [NumRequesters-1:0]                      pwrite_in,
  input  logic [NumRequesters-1:0][ApbDataWidth-1:0]    pwdata_in,
  output logic [NumRequesters-1:0][ApbDataWidth-1:0]    prdata_out,
  output logic [NumRequesters-1:0]                      pready_out,
  output logic [NumRequesters-1:0]                      pslverr_out,
  output logic [AddrWidth-1:0]                          paddr_out,
  output logic                                          psel_out,
  output logic                                          penable_out,
  output logic [ApbProtWidth-1:0]                       pprot_out,
  output logic [ApbStrbWidth-1:0]                       pstrb_out,
  output logic                                          pwrite_out,
  output logic [ApbDataWidth-1:0]                       pwdata_out,
  input  logic [ApbDataWidth-1:0]                       prdata_in,
  input  logic                                          pready_in,
  input  logic                                          pslverr_in
);
  localparam int IdxWidth = $clog2(NumRequesters);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                   state;
  logic [IdxWidth-1:0]      gnt_idx;
  logic [NumRequesters-1:0] arb_req;
  logic [NumRequesters-1:0] arb_grant;
  logic [IdxWidth-1:0]      arb_idx;
  logic                     arb_update;
  logic                     done;

  // Requests are only visible to the arbiter while no transfer is in flight.
  assign arb_req    = (state == IDLE) ? psel_in : '0;
  assign arb_update = |arb_req;
  assign done       = (state == ACCESS) && pready_in;

  br_arb_rr #(
    .NumRequesters(NumRequesters)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .request   (arb_req),
    .update    (arb_update),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt_idx     <= '0;
      paddr_out   <= '0;
      psel_out    <= 1'b0;
      penable_out <= 1'b0;
      pprot_out   <= '0;
      pstrb_out   <= '0;
      pwrite_out  <= 1'b0;
      pwdata_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_update) begin
            gnt_idx     <= arb_idx;
            paddr_out   <= paddr_in[arb_idx];
            pprot_out   <= pprot_in[arb_idx];
            pstrb_out   <= pstrb_in[arb_idx];
            pwrite_out  <= pwrite_in[arb_idx];
            pwdata_out  <= pwdata_in[arb_idx];
            psel_out    <= 1'b1;
            penable_out <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable_out <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          // Upstream psel drops during the transfer are ignored; only the target ends it.
          if (pready_in) begin
            paddr_out   <= '0;
            psel_out    <= 1'b0;
            penable_out <= 1'b0;
            pprot_out   <= '0;
            pstrb_out   <= '0;
            pwrite_out  <= 1'b0;
            pwdata_out  <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pready_out  = '0;
    pslverr_out = '0;
    prdata_out  = '0;
    if (done) begin
      pready_out[gnt_idx]  = 1'b1;
      pslverr_out[gnt_idx] = pslverr_in;
      prdata_out[gnt_idx]  = prdata_in;
    end
  end

`ifndef SYNTHESIS
  for (genvar i = 0; i < NumRequesters; i++) begin : g_req_chk
    a_req_stable : assert property (@(posedge clk) disable iff (rst)
      psel_in[i] && !pready_out[i] |=>
        $stable(paddr_in[i]) && $stable(pprot_in[i]) && $stable(pstrb_in[i]) &&
        $stable(pwrite_in[i]) && $stable(pwdata_in[i]));
    a_req_enable : assert property (@(posedge clk) disable iff (rst)
      penable_in[i] |-> psel_in[i]);
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(arb_grant));

  a_down_stable : assert property (@(posedge clk) disable iff (rst)
    psel_out && !done |=>
      psel_out && $stable(paddr_out) && $stable(pprot_out) && $stable(pstrb_out) &&
      $stable(pwrite_out) && $stable(pwdata_out));
`endif
endmodule

// File: tb/tb_br_amba_apb_arbiter.sv
// Directed and randomized checks of the APB arbiter against a transaction-level model.
module tb_br_amba_apb_arbiter;
  import br_amba::*;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int PW = ApbProtWidth;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N-1:0][AW-1:0]      paddr_in;
  logic [N-1:0]              psel_in, penable_in, pwrite_in;
  logic [N-1:0][PW-1:0]      pprot_in;
  logic [N-1:0][3:0]         pstrb_in;
  logic [N-1:0][31:0]        pwdata_in;
  logic [N-1:0][31:0]        prdata_out;
  logic [N-1:0]              pready_out, pslverr_out;
  logic [AW-1:0]             paddr_out;
  logic                      psel_out, penable_out, pwrite_out;
  logic [PW-1:0]             pprot_out;
  logic [3:0]                pstrb_out;
  logic [31:0]               pwdata_out;
  logic [31:0]               prdata_in;
  logic                      pready_in, pslverr_in;

  int vecs = 0;
  int errs = 0;

  logic [AW-1:0] exp_a [N];
  logic [31:0]   exp_d [N];
  logic          exp_w [N];
  logic [PW-1:0] exp_p [N];
  logic [3:0]    exp_s [N];

  br_amba_apb_arbiter #(.NumRequesters(N), .AddrWidth(AW)) dut (
    .clk(clk), .rst(rst),
    .paddr_in(paddr_in), .psel_in(psel_in), .penable_in(penable_in), .pprot_in(pprot_in),
    .pstrb_in(pstrb_in), .pwrite_in(pwrite_in), .pwdata_in(pwdata_in),
    .prdata_out(prdata_out), .pready_out(pready_out), .pslverr_out(pslverr_out),
    .paddr_out(paddr_out), .psel_out(psel_out), .penable_out(penable_out), .pprot_out(pprot_out),
    .pstrb_out(pstrb_out), .pwrite_out(pwrite_out), .pwdata_out(pwdata_out),
    .prdata_in(prdata_in), .pready_in(pready_in), .pslverr_in(pslverr_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input int i, input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                     input logic [PW-1:0] p, input logic [3:0] s);
    exp_a[i] = a; exp_d[i] = d; exp_w[i] = w; exp_p[i] = p; exp_s[i] = s;
    paddr_in[i] = a; pwdata_in[i] = d; pwrite_in[i] = w; pprot_in[i] = p; pstrb_in[i] = s;
    psel_in[i] = 1'b1;
  endtask

  task automatic drop(input int i);
    psel_in[i] = 1'b0;
  endtask

  task automatic chk_ctrl(input string tag, input int w);
    chk({tag, "_addr"},  paddr_out,  exp_a[w]);
    chk({tag, "_wdata"}, pwdata_out, exp_d[w]);
    chk({tag, "_write"}, pwrite_out, exp_w[w]);
    chk({tag, "_prot"},  pprot_out,  exp_p[w]);
    chk({tag, "_strb"},  pstrb_out,  exp_s[w]);
  endtask

  // Called in the IDLE decision cycle; returns in the cycle after completion.
  task automatic serve(input int w, input int waits, input logic [31:0] rd, input logic err);
    logic [N-1:0] one;
    one = '0;
    one[w] = 1'b1;
    settle();
    chk("idle_psel", psel_out, 0);
    chk("idle_rdy", pready_out, 0);
    tick();
    chk("setup_psel", psel_out, 1);
    chk("setup_pen", penable_out, 0);
    chk_ctrl("setup", w);
    tick();
    chk("access_pen", penable_out, 1);
    for (int k = 0; k < waits; k++) begin
      pready_in = 1'b0;
      settle();
      chk("wait_rdy", pready_out, 0);
      chk("wait_psel", psel_out, 1);
      chk("wait_pen", penable_out, 1);
      chk_ctrl("wait", w);
      tick();
    end
    pready_in = 1'b1; prdata_in = rd; pslverr_in = err;
    settle();
    chk("done_rdy", pready_out, one);
    chk("done_data", prdata_out[w], rd);
    chk("done_other_data", prdata_out[(w + 1) % N], 0);
    chk("done_err", pslverr_out, err ? one : {N{1'b0}});
    tick();
    pready_in = 1'b0; prdata_in = '0; pslverr_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Random-phase model state
  bit   active [N];
  int   issued [N];
  int   done_cnt [N];
  int   starve [N];
  bit   m_busy, m_setup;
  int   m_ptr, m_w, obs_w, j;
  logic [N-1:0] exp_rdy, exp_err;
  logic [N-1:0] any_active;

  initial begin
    rst = 1'b1;
    paddr_in = '0; psel_in = '0; penable_in = '0; pprot_in = '0; pstrb_in = '0;
    pwrite_in = '0; pwdata_in = '0; prdata_in = '0; pready_in = 1'b0; pslverr_in = 1'b0;
    tick();
    tick();
    chk("rst_psel", psel_out, 0);
    chk("rst_pen", penable_out, 0);
    chk("rst_addr", paddr_out, 0);
    chk("rst_wdata", pwdata_out, 0);
    chk("rst_rdy", pready_out, 0);
    rst = 1'b0;
    tick();

    // Single read: pready from the target at t+4
    req(0, 12'h010, 1'b0, 32'h0, 3'd0, 4'h0);
    serve(0, 2, 32'hCAFE_0001, 1'b0);
    drop(0);
    settle();
    chk("read_after_rdy", pready_out, 0);
    chk("read_after_data", prdata_out[0], 0);
    chk("read_after_psel", psel_out, 0);
    tick();

    // Contention from reset, then both held: grants alternate 0,1,0,1...
    do_reset();
    req(0, 12'h100, 1'b1, 32'hA0A0_0000, 3'd1, 4'hF);
    req(1, 12'h200, 1'b1, 32'hB0B0_0000, 3'd2, 4'h3);
    for (int k = 0; k < 6; k++) begin
      serve(k % 2, k % 3, 32'h0, 1'b0);
      req(k % 2, AW'(12'h300 + 4 * k), 1'(k), 32'hC000_0000 + 32'(k), 3'(k), 4'(k));
    end
    drop(0);
    drop(1);
    settle();
    tick();

    // Wait states
    req(2, 12'h3FC, 1'b1, 32'h5555_AAAA, 3'd5, 4'hC);
    serve(2, 5, 32'h0, 1'b0);
    drop(2);
    settle();
    tick();

    // Slave error on a write from requester 1
    req(1, 12'h044, 1'b1, 32'h1234_5678, 3'd2, 4'hF);
    serve(1, 1, 32'h0, 1'b1);
    drop(1);
    settle();
    chk("err_after", pslverr_out, 0);
    tick();

    // Async reset during ACCESS; pointer must restart at 0 so req1 beats req3
    req(1, 12'h0AA, 1'b0, 32'h0, 3'd0, 4'h0);
    tick();
    tick();
    settle();
    chk("pre_rst_pen", penable_out, 1);
    rst = 1'b1;
    req(3, 12'h333, 1'b1, 32'h3333_3333, 3'd3, 4'h1);
    settle();
    chk("async_psel", psel_out, 0);
    chk("async_pen", penable_out, 0);
    chk("async_addr", paddr_out, 0);
    tick();
    rst = 1'b0;
    serve(1, 0, 32'hBEEF_0002, 1'b0);
    drop(1);
    serve(3, 1, 32'h0, 1'b0);
    drop(3);
    settle();
    tick();

    // Randomized traffic against a transaction-level model
    do_reset();
    psel_in = '0;
    m_busy = 1'b0; m_setup = 1'b0; m_ptr = 0; m_w = -1;
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0; issued[i] = 0; done_cnt[i] = 0; starve[i] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!active[i]) begin
          if (c < 3600 && $urandom_range(0, 3) == 0) begin
            req(i, AW'($urandom), 1'($urandom), $urandom, PW'($urandom), 4'($urandom));
            active[i] = 1'b1;
            issued[i]++;
          end else begin
            drop(i);
          end
        end
      end
      pready_in  = ($urandom_range(0, 2) == 0);
      prdata_in  = $urandom;
      pslverr_in = ($urandom_range(0, 3) == 0);
      settle();
      if (!m_busy) begin
        chk("rnd_idle_psel", psel_out, 0);
        chk("rnd_idle_pen", penable_out, 0);
        chk("rnd_idle_rdy", pready_out, 0);
        m_w = -1;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (m_w < 0 && active[j]) m_w = j;
        end
        if (m_w >= 0) begin
          m_ptr = (m_w + 1) % N;
          m_busy = 1'b1;
          m_setup = 1'b1;
        end
      end else if (m_setup) begin
        chk("rnd_setup_psel", psel_out, 1);
        chk("rnd_setup_pen", penable_out, 0);
        chk("rnd_setup_rdy", pready_out, 0);
        chk_ctrl("rnd_setup", m_w);
        obs_w = -1;
        for (int i = 0; i < N; i++)
          if (active[i] && paddr_out == exp_a[i] && pwdata_out == exp_d[i] && pwrite_out == exp_w[i])
            obs_w = i;
        chk("rnd_owner", obs_w, m_w);
        for (int i = 0; i < N; i++) begin
          if (active[i] && i != obs_w) begin
            starve[i]++;
            chk("rnd_starve", starve[i] <= 3, 1);
          end
        end
        if (obs_w >= 0) starve[obs_w] = 0;
        m_setup = 1'b0;
      end else begin
        chk("rnd_acc_psel", psel_out, 1);
        chk("rnd_acc_pen", penable_out, 1);
        chk_ctrl("rnd_acc", m_w);
        exp_rdy = '0;
        exp_err = '0;
        if (pready_in) begin
          exp_rdy[m_w] = 1'b1;
          exp_err[m_w] = pslverr_in;
        end
        chk("rnd_rdy", pready_out, exp_rdy);
        chk("rnd_err", pslverr_out, exp_err);
        for (int i = 0; i < N; i++)
          chk("rnd_data", prdata_out[i], (pready_in && i == m_w) ? prdata_in : 32'h0);
        if (pready_in) begin
          done_cnt[m_w]++;
          active[m_w] = 1'b0;
          m_busy = 1'b0;
        end
      end
      tick();
    end
    pready_in = 1'b0;
    any_active = '0;
    for (int i = 0; i < N; i++) begin
      chk("rnd_count", done_cnt[i], issued[i]);
      any_active[i] = active[i];
    end
    chk("rnd_drained", any_active, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
